imem_loader: RTL and testbench

Boot-time program loader that writes the core's 64-word instruction cache from a byte stream and holds the core in reset until the image is verified. It sits between an external byte source (UART receiver or testbench) and the write port of the instruction memory. The core's fetch path only reads that memory; this block is the write side of the same storage. It drives the core's active-low reset and releases the core only after a complete, checksum-verified image has been written.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction-memory write port bundle
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;

  // byte source and memory side
  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  // loader side
  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing instruction memory from a checksummed byte stream
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  imem_loader_if.slave bus,
  output logic         cpu_rst_no,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_ready;
  logic                r_done;
  logic                r_err;
  logic                r_cpu_rst_n;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic [ADDR_W-1:0]   r_hdr;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic [1:0]          r_byte_cnt;
  logic [7:0]          r_xor;
  logic [DATA_W-9:0]   r_shift;

  logic                w_acc;
  logic                w_hdr_big;
  logic                w_last_byte;
  logic                w_last_word;
  logic                w_ready_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic                w_cpu_rst_n_nxt;
  logic                w_wr_en_nxt;

  assign w_acc       = bus.byte_valid_i & r_ready;
  // any header bit at or above ADDR_W means more words than the memory holds
  assign w_hdr_big   = ((32'(bus.byte_i) >> ADDR_W) != 32'd0);
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = (r_word_cnt == r_hdr);

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_HDR;
    else       r_state <= w_state_nxt;
  end

  // next-state decode; DONE and ERR only leave through reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR:   if (w_acc) w_state_nxt = w_hdr_big ? S_ERR : S_DATA;
      S_DATA:  if (w_acc && w_last_byte && w_last_word) w_state_nxt = S_CHK;
      S_CHK:   if (w_acc) w_state_nxt = (bus.byte_i == r_xor) ? S_DONE : S_ERR;
      default: w_state_nxt = r_state;
    endcase
  end

  // output decode from the next state so the registered outputs track the state
  always_comb begin
    w_ready_nxt     = (w_state_nxt == S_HDR) || (w_state_nxt == S_DATA) || (w_state_nxt == S_CHK);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_err_nxt       = (w_state_nxt == S_ERR);
    w_cpu_rst_n_nxt = (w_state_nxt == S_DONE);
    w_wr_en_nxt     = (r_state == S_DATA) && w_acc && w_last_byte;
  end

  // registered status and write strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      r_ready     <= w_ready_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_cpu_rst_n <= w_cpu_rst_n_nxt;
      r_wr_en     <= w_wr_en_nxt;
    end
  end

  // header capture, word assembly, checksum accumulation and write address/data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hdr      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_xor      <= '0;
      r_shift    <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else if (w_acc && (r_state == S_HDR)) begin
      r_hdr      <= bus.byte_i[ADDR_W-1:0];
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_xor      <= '0;
    end else if (w_acc && (r_state == S_DATA)) begin
      r_xor      <= r_xor ^ bus.byte_i;
      r_byte_cnt <= r_byte_cnt + 2'd1;
      if (w_last_byte) begin
        r_wr_addr  <= r_word_cnt;
        r_wr_data  <= {bus.byte_i, r_shift};
        r_word_cnt <= r_word_cnt + 1'b1;
      end else begin
        r_shift[{r_byte_cnt, 3'b000} +: 8] <= bus.byte_i;
      end
    end
  end

  assign bus.byte_ready_o = r_ready;
  assign bus.wr_en_o      = r_wr_en;
  assign bus.wr_addr_o    = r_wr_addr;
  assign bus.wr_data_o    = r_wr_data;
  assign cpu_rst_no       = r_cpu_rst_n;
  assign done_o           = r_done;
  assign err_o            = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst_n;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_W(6), .DATA_W(32)) ifc ();

  imem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (ifc),
    .cpu_rst_no (cpu_rst_n),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_writes = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [7:0]  h;
    logic [31:0] w;
    logic [7:0]  c;
    bit          hdr_ok;
    bit          exp_done;
  } vec_t;
  vec_t vt[5];

  logic [31:0] img[64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wxor(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // scoreboard: every write pulse must match the oldest outstanding expected word
  always @(negedge clk) begin
    if (ifc.wr_en_o === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ifc.wr_addr_o), 32'(e.addr));
        check("wr_data", ifc.wr_data_o, e.data);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap, input bit expect_acc);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    ifc.byte_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    ifc.byte_i = b;
    ifc.byte_valid_i = 1'b1;
    do begin
      @(negedge clk);
      acc = ifc.byte_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < (expect_acc ? 50 : 3));
    ifc.byte_valid_i = 1'b0;
    if (expect_acc) check("byte_accepted", 32'(acc), 32'd1);
    else            check("byte_ignored", 32'(acc), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [5:0] addr, input int gapmax);
    wr_t e;
    logic [31:0] ww;
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    ww = w;
    for (int j = 0; j < 4; j++)
      send_byte(ww[8*j +: 8], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(ifc.byte_ready_o), 32'd1);
    check("rst_wr_en", 32'(ifc.wr_en_o), 32'd0);
    check("rst_wr_addr", 32'(ifc.wr_addr_o), 32'd0);
    check("rst_wr_data", ifc.wr_data_o, 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
  endtask

  task automatic check_status(input string tag, input bit exp_done);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(!exp_done));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
    check({tag, "_ready"}, 32'(ifc.byte_ready_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int w0;
    logic [7:0] x;
    logic [31:0] vw;

    ifc.byte_i = 8'h00;
    ifc.byte_valid_i = 1'b0;

    vt[0] = '{h: 8'h00, w: 32'h0000_0513, c: 8'h16, hdr_ok: 1'b1, exp_done: 1'b1};
    vt[1] = '{h: 8'h00, w: 32'h0000_0513, c: 8'h17, hdr_ok: 1'b1, exp_done: 1'b0};
    vt[2] = '{h: 8'h40, w: 32'h0000_0513, c: 8'h16, hdr_ok: 1'b0, exp_done: 1'b0};
    vt[3] = '{h: 8'hFF, w: 32'h1234_5678, c: 8'h08, hdr_ok: 1'b0, exp_done: 1'b0};
    vt[4] = '{h: 8'h00, w: 32'hDEAD_BEEF, c: 8'h22, hdr_ok: 1'b1, exp_done: 1'b1};

    @(posedge clk);
    #1;

    // single-word images, bad checksum and oversize headers
    for (int i = 0; i < 5; i++) begin
      do_reset();
      w0 = n_writes;
      vw = vt[i].w;
      send_byte(vt[i].h, 0, 1'b1);
      if (!vt[i].hdr_ok) begin
        check("oversize_err", 32'(err), 32'd1);
        check("oversize_ready", 32'(ifc.byte_ready_o), 32'd0);
        for (int j = 0; j < 4; j++) send_byte(vw[8*j +: 8], 0, 1'b0);
        check("oversize_no_write", 32'(n_writes - w0), 32'd0);
      end else begin
        send_word(vt[i].w, 6'd0, 0);
        send_byte(vt[i].c, 0, 1'b1);
      end
      check_status("vec", vt[i].exp_done);
      repeat (2) @(posedge clk);
      #1;
      check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // full image with random valid gaps
    do_reset();
    w0 = n_writes;
    x = 8'h00;
    for (int k = 0; k < 64; k++) begin
      img[k] = $urandom;
      x = x ^ wxor(img[k]);
    end
    send_byte(8'h3F, 1, 1'b1);
    for (int k = 0; k < 64; k++) send_word(img[k], 6'(k), 3);
    send_byte(x, 2, 1'b1);
    check_status("gaps", 1'b1);
    check("gaps_writes", 32'(n_writes - w0), 32'd64);
    check("gaps_queue_empty", 32'(exp_q.size()), 32'd0);

    // full image at full rate, timed from header drive to done
    do_reset();
    x = 8'h00;
    for (int k = 0; k < 64; k++) begin
      img[k] = $urandom;
      x = x ^ wxor(img[k]);
    end
    t0 = cyc;
    send_byte(8'h3F, 0, 1'b1);
    for (int k = 0; k < 64; k++) send_word(img[k], 6'(k), 0);
    check("fullrate_done_early", 32'(done), 32'd0);
    send_byte(x, 0, 1'b1);
    check("fullrate_cycles", 32'(cyc - t0), 32'd258);
    check_status("fullrate", 1'b1);

    // reset mid-load after two bytes of word 5, then a fresh one-word image
    do_reset();
    send_byte(8'h07, 0, 1'b1);
    for (int k = 0; k < 5; k++) send_word(32'h1111_0000 + 32'(k), 6'(k), 0);
    send_byte(8'hA1, 0, 1'b1);
    send_byte(8'hA2, 0, 1'b1);
    check("midload_queue_empty", 32'(exp_q.size()), 32'd0);
    do_reset();
    send_byte(8'h00, 0, 1'b1);
    send_word(32'hCAFE_F00D, 6'd0, 1);
    send_byte(wxor(32'hCAFE_F00D), 0, 1'b1);
    check_status("midload", 1'b1);

    // backpressure in DONE
    w0 = n_writes;
    ifc.byte_i = 8'hAA;
    ifc.byte_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(ifc.byte_ready_o), 32'd0);
      check("bp_done", 32'(done), 32'd1);
      check("bp_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    end
    @(posedge clk);
    #1;
    ifc.byte_valid_i = 1'b0;
    check("bp_no_write", 32'(n_writes - w0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
